// File: rtl/matmult_arb2.sv
// Two-requester round-robin front end for a 2x2 matrix-multiply unit.
// Captures one requester's operands, runs a single job through the unit, then returns the result.
module matmult_arb2 #(
  parameter int TIMEOUT = 15,
  parameter int DATA_W  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rq0_req,
  input  logic                rq1_req,
  input  logic [4*DATA_W-1:0] rq0_a,
  input  logic [4*DATA_W-1:0] rq0_b,
  input  logic [4*DATA_W-1:0] rq1_a,
  input  logic [4*DATA_W-1:0] rq1_b,
  output logic                rq0_grant,
  output logic                rq1_grant,
  output logic                rq0_done,
  output logic                rq1_done,
  output logic [4*DATA_W-1:0] res_c,
  output logic                mm_ready,
  output logic [4*DATA_W-1:0] mm_in_a,
  output logic [4*DATA_W-1:0] mm_in_b,
  input  logic                mm_valid,
  input  logic [4*DATA_W-1:0] mm_out_c,
  output logic                mm_accept,
  output logic                err_timeout,
  output logic [15:0]         job_cnt
);

  localparam int MAT_W = 4 * DATA_W;
  localparam int WD_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_gnt;   // 1: requester 1 was granted most recently
  logic              owner;      // requester that owns the job in flight
  logic              any_req;
  logic              win1;
  logic              grant_en;
  logic [WD_W-1:0]   wd_cnt;
  logic [MAT_W-1:0]  op_a_p0;
  logic [MAT_W-1:0]  op_b_p0;
  logic [MAT_W-1:0]  res_c_p1;

  // On a tie the requester not served last wins; a lone request always wins.
  function automatic logic pick_rq1(input logic r0, input logic r1, input logic last1);
    if (r0 && r1) begin
      return !last1;
    end
    return r1;
  endfunction

  always_comb begin
    state_nxt = state;
    any_req   = rq0_req | rq1_req;
    win1      = pick_rq1(rq0_req, rq1_req, last_gnt);
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_WAIT;
      S_WAIT:    if (mm_valid) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_DRAIN;
      S_DRAIN:   if (!mm_valid) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Grant is combinational so operands are captured on the edge that leaves IDLE;
  // it is masked during reset so nothing is granted while rst is high.
  assign grant_en  = (state == S_IDLE) && any_req && !rst;
  assign rq0_grant = grant_en && !win1;
  assign rq1_grant = grant_en && win1;

  assign mm_ready  = (state == S_LAUNCH);
  assign mm_accept = (state == S_RELEASE);
  assign rq0_done  = (state == S_RELEASE) && !owner;
  assign rq1_done  = (state == S_RELEASE) && owner;

  assign mm_in_a   = op_a_p0;
  assign mm_in_b   = op_b_p0;
  assign res_c     = res_c_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last_gnt    <= 1'b1;
      owner       <= 1'b0;
      job_cnt     <= 16'd0;
      err_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state <= state_nxt;
      if (grant_en) begin
        owner    <= win1;
        last_gnt <= win1;
      end
      if (state == S_RELEASE) begin
        job_cnt <= job_cnt + 16'd1;
      end
      // Watchdog: restarts for every job, saturates, and the flag is sticky.
      if (state == S_LAUNCH) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) && !mm_valid) begin
        if (wd_cnt != WD_MAX) begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        if (wd_cnt == WD_LAST) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

  // p0: operands latched at grant, held until the next grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_p0 <= '0;
      op_b_p0 <= '0;
    end else if (grant_en) begin
      op_a_p0 <= win1 ? rq1_a : rq0_a;
      op_b_p0 <= win1 ? rq1_b : rq0_b;
    end
  end

  // p1: result captured on the first valid cycle of WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_c_p1 <= '0;
    end else if ((state == S_WAIT) && mm_valid) begin
      res_c_p1 <= mm_out_c;
    end
  end

endmodule

// File: doc/matmult_arb2.md
MATMULT_ARB2 -- requirements
Module: matmult_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: WAIT-state cycles without mm_valid before error flag sets.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rq0_req / rq1_req  input  1  level request from requester 0/1.
REQ-005 SHALL have ports rq0_a, rq0_b, rq1_a, rq1_b  input  256  packed 2x2 operands; element k at [64k+63:64k], k=0..3 row-major, signed.
REQ-006 SHALL have ports rq0_grant / rq1_grant  output  1  one-cycle pulse: operands captured.
REQ-007 SHALL have ports rq0_done / rq1_done  output  1  one-cycle pulse: res_c valid for that requester.
REQ-008 SHALL have port res_c  output  256  registered result, same packing, held until next capture.
REQ-009 SHALL have ports mm_ready  output  1, mm_in_a / mm_in_b  output  256: start strobe and operands to the matmult unit.
REQ-010 SHALL have ports mm_valid  input  1, mm_out_c  input  256, mm_accept  output  1: result handshake with the unit.
REQ-011 SHALL have ports err_timeout  output  1 (sticky) and job_cnt  output  16 (completed jobs, wraps).

Function
REQ-012 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RELEASE -> DRAIN -> IDLE.
REQ-013 IDLE: if any rqN_req high, SHALL select winner, latch its a/b into internal operand registers, pulse rqN_grant, go LAUNCH.
REQ-014 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted last wins; pointer resets so requester 0 wins first tie.
REQ-015 LAUNCH: mm_ready=1 for exactly one cycle; mm_in_a/mm_in_b driven from latched operands and held stable from LAUNCH through end of DRAIN.
REQ-016 WAIT: mm_ready=0; on first cycle mm_valid=1 SHALL capture mm_out_c into res_c, go RELEASE; rqN_done pulses in RELEASE cycle for the latched owner.
REQ-017 RELEASE: mm_accept=1 for exactly one cycle, job_cnt increments by 1 (0xFFFF wraps to 0), go DRAIN.
REQ-018 DRAIN: mm_accept=0; SHALL stay until mm_valid=0, then IDLE; no new launch while mm_valid=1.
REQ-019 WAIT watchdog: counter clears on WAIT entry; on reaching TIMEOUT without mm_valid SHALL set err_timeout and keep waiting; err_timeout clears only on reset.
REQ-020 Requests arriving outside IDLE SHALL be held pending (level), never dropped or granted twice; rqN_req still high after done means a new job.
REQ-021 At most one grant per job; grant and done never both asserted for the same requester in one cycle.
REQ-022 With the 3-state unit (idle/calc/fin, registered valid), done SHALL occur 4 cycles after LAUNCH; grant-to-grant for back-to-back jobs 7 cycles.
REQ-023 Arithmetic is done solely in the unit; arbiter SHALL pass data bit-exact with no width change.

Reset
REQ-024 On rst=1, asynchronously: state IDLE, all grant/done/mm_ready/mm_accept 0, res_c 0, mm_in_a/mm_in_b 0, job_cnt 0, err_timeout 0, RR pointer favouring requester 0.
REQ-025 Reset mid-job SHALL abandon the job with no done pulse; first grant after release follows REQ-013 on the next clock.

Verification
REQ-026 Single job: rq0_req, a=[1,2,3,4], b=[5,6,7,8] -> rq0_grant pulse, mm_ready pulse next cycle, rq0_done 4 cycles later, res_c=[19,22,43,50], job_cnt=1.
REQ-027 Tie: rq0_req and rq1_req high together and held -> grants alternate 0,1,0,1; each done matches its own operands; no overlap of mm_ready with mm_valid.
REQ-028 Signed data: a=[-1,2,0,-3], b=[4,-5,6,7] via rq1 -> res_c=[8,19,-18,-21] on rq1_done.
REQ-029 Timeout: unit model withholds mm_valid for 20 cycles, TIMEOUT=15 -> err_timeout rises after 15 WAIT cycles, job still completes on valid, flag stays 1.
REQ-030 Reset in WAIT: assert rst two cycles after LAUNCH -> outputs 0 immediately without clock edge, no done pulse, job_cnt 0; post-reset rq1 request granted normally.
